// File: rtl/mem_access_if.sv
// Signal bundle between the EX stage, the data memory and the write-back stage
// for the memory-access pipeline stage.
interface mem_access_if;
    // Handshake: ex_valid marks an instruction offered by EX. There is no ready;
    // the pipeline's stall/flush inputs on the stage decide whether it is taken.
    logic        ex_valid;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [31:0] ex_alu_result;
    logic [4:0]  ex_rd;
    logic        ex_wb_en;

    logic        dm_ena;
    logic        dm_wena;
    logic [1:0]  dm_wsel;
    logic [1:0]  dm_rsel;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic        mem_wb_en;
    logic [31:0] mem_result;
    logic        exc;
    logic [31:0] bad_addr;
    logic        dbg_store_done;

    modport master (
        input  ex_valid, ex_mem_op, ex_addr, ex_wdata, ex_alu_result, ex_rd, ex_wb_en,
        input  dm_rdata,
        output dm_ena, dm_wena, dm_wsel, dm_rsel, dm_addr, dm_wdata,
        output mem_valid, mem_rd, mem_wb_en, mem_result, exc, bad_addr, dbg_store_done
    );

    modport slave (
        output ex_valid, ex_mem_op, ex_addr, ex_wdata, ex_alu_result, ex_rd, ex_wb_en,
        output dm_rdata,
        input  dm_ena, dm_wena, dm_wsel, dm_rsel, dm_addr, dm_wdata,
        input  mem_valid, mem_rd, mem_wb_en, mem_result, exc, bad_addr, dbg_store_done
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: holds one instruction, drives the data-memory
// port, checks alignment/range faults and formats load results for write-back.
module mem_access_stage #(
    parameter logic [31:0] DMEM_BASE  = 32'h10010000,
    parameter int unsigned DMEM_BYTES = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    mem_access_if.master  bus
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_WORD = 2'b01;
    localparam logic [1:0] SEL_HALF = 2'b10;
    localparam logic [1:0] SEL_BYTE = 2'b11;

    // Window end computed one bit wider so a window touching 2^32 cannot wrap.
    localparam logic [32:0] DMEM_END = {1'b0, DMEM_BASE} + {1'b0, 32'(DMEM_BYTES)};

    logic        r_valid;
    logic [3:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_alu_result;
    logic [4:0]  r_rd;
    logic        r_wb_en;
    logic        r_store_done;
    logic [31:0] r_bad_addr;

    logic        w_is_load;
    logic        w_is_store;
    logic [1:0]  w_size_sel;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_exc;
    logic        w_access;
    logic        w_dm_wena;
    logic [31:0] w_result;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size_sel = SEL_IDLE;
        case (r_op)
            OP_LW:         begin w_is_load  = 1'b1; w_size_sel = SEL_WORD; end
            OP_LH, OP_LHU: begin w_is_load  = 1'b1; w_size_sel = SEL_HALF; end
            OP_LB, OP_LBU: begin w_is_load  = 1'b1; w_size_sel = SEL_BYTE; end
            OP_SW:         begin w_is_store = 1'b1; w_size_sel = SEL_WORD; end
            OP_SH:         begin w_is_store = 1'b1; w_size_sel = SEL_HALF; end
            OP_SB:         begin w_is_store = 1'b1; w_size_sel = SEL_BYTE; end
            default:       begin w_is_load  = 1'b0; w_is_store = 1'b0; end
        endcase
    end

    always_comb begin
        w_misaligned   = ((w_size_sel == SEL_WORD) && (r_addr[1:0] != 2'b00)) ||
                         ((w_size_sel == SEL_HALF) && r_addr[0]);
        w_out_of_range = ({1'b0, r_addr} < {1'b0, DMEM_BASE}) ||
                         ({1'b0, r_addr} >= DMEM_END);
        w_exc          = r_valid && (w_is_load || w_is_store) && (w_misaligned || w_out_of_range);
        w_access       = r_valid && (w_is_load || w_is_store) && !w_exc;
        w_dm_wena      = w_access && w_is_store && !r_store_done;
    end

    always_comb begin
        w_result = r_alu_result;
        case (r_op)
            OP_LW:   w_result = bus.dm_rdata;
            OP_LH:   w_result = {{16{bus.dm_rdata[15]}}, bus.dm_rdata[15:0]};
            OP_LHU:  w_result = {16'h0000, bus.dm_rdata[15:0]};
            OP_LB:   w_result = {{24{bus.dm_rdata[7]}}, bus.dm_rdata[7:0]};
            OP_LBU:  w_result = {24'h000000, bus.dm_rdata[7:0]};
            default: w_result = r_alu_result;
        endcase
    end

    // store_done remembers that a stalled store already wrote, so it writes once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_op         <= 4'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_alu_result <= 32'd0;
            r_rd         <= 5'd0;
            r_wb_en      <= 1'b0;
            r_store_done <= 1'b0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_store_done <= 1'b0;
        end else if (stall) begin
            if (w_dm_wena) begin
                r_store_done <= 1'b1;
            end
        end else begin
            r_valid      <= bus.ex_valid;
            r_op         <= bus.ex_mem_op;
            r_addr       <= bus.ex_addr;
            r_wdata      <= bus.ex_wdata;
            r_alu_result <= bus.ex_alu_result;
            r_rd         <= bus.ex_rd;
            r_wb_en      <= bus.ex_wb_en;
            r_store_done <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bad_addr <= 32'd0;
        end else if (w_exc) begin
            r_bad_addr <= r_addr;
        end
    end

    assign bus.dm_ena         = w_access;
    assign bus.dm_wena        = w_dm_wena;
    assign bus.dm_rsel        = (w_access && w_is_load)  ? w_size_sel : SEL_IDLE;
    assign bus.dm_wsel        = (w_access && w_is_store) ? w_size_sel : SEL_IDLE;
    assign bus.dm_addr        = w_access ? r_addr  : 32'd0;
    assign bus.dm_wdata       = w_access ? r_wdata : 32'd0;
    assign bus.mem_valid      = r_valid;
    assign bus.mem_rd         = r_rd;
    assign bus.mem_wb_en      = r_valid && r_wb_en && !w_exc;
    assign bus.mem_result     = w_result;
    assign bus.exc            = w_exc;
    // The faulting address is visible while the fault is held, then kept.
    assign bus.bad_addr       = w_exc ? r_addr : r_bad_addr;
    assign bus.dbg_store_done = r_store_done;

endmodule
